// File: rtl/router_pkg.sv
// Shared router definitions: datapath widths, egress FSM encoding and
// small helpers used by the egress/ingress blocks.
package router_pkg;

   localparam int AURORA_WIDTH  = 256;
   localparam int ROUTER_WIDTH  = 256;
   localparam int NUM_OUT_PORTS = 3;

   typedef enum logic [1:0] {
      EG_IDLE  = 2'b00,
      EG_FETCH = 2'b01,
      EG_SEND  = 2'b10
   } egress_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [15:0] wrap_inc16(input logic [15:0] v);
      return v + 16'd1;
   endfunction

endpackage

// File: rtl/egress_fifo.sv
// Egress packet buffer: circular storage with registered occupancy count.
// Flags are decoded from the count register only, never from same-edge traffic.
module egress_fifo #(
   parameter int WIDTH        = 256,
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 2,
   localparam int PTR_W       = $clog2(DEPTH),
   localparam int CNT_W       = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_req,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic             wr_drop
);

   localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_ok;

   assign full        = (count == FULL_LVL);
   assign almost_full = (count >= AFULL_LVL);
   assign empty       = (count == '0);

   // A pop on the same edge does not free a slot for a write while full.
   assign wr_en   = wr_req & ~full;
   assign wr_drop = wr_req & full;
   assign rd_ok   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({wr_en, rd_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/egress_tx.sv
// Switch output port to Aurora AXI4-Stream TX bridge: single-beat packets
// drained from an egress buffer, with drop and sent-packet counters.
//
// state    | meaning
// EG_IDLE  | no packet in flight; tx_tdata forced to 0
// EG_FETCH | popping the buffer head into tx_tdata
// EG_SEND  | tx_tvalid high, waiting for tx_tready
module egress_tx #(
   parameter int AURORA_WIDTH = router_pkg::AURORA_WIDTH,
   parameter int FIFO_DEPTH   = 8,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we_in,
   input  logic [AURORA_WIDTH-1:0]   data_in,
   output logic                      full,
   output logic                      almost_full,
   input  logic                      channel_up,
   output logic [AURORA_WIDTH-1:0]   tx_tdata,
   output logic                      tx_tvalid,
   input  logic                      tx_tready,
   output logic                      tx_tlast,
   output logic [AURORA_WIDTH/8-1:0] tx_tkeep,
   output logic [7:0]                overflow_cnt,
   output logic [15:0]               tx_pkt_cnt
);

   import router_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   egress_state_t             state;
   logic [AURORA_WIDTH-1:0]   fifo_rd_data;
   logic [CNT_W-1:0]          fifo_count;
   logic                      fifo_empty;
   logic                      fifo_drop;
   logic                      fifo_pop;

   egress_fifo #(
      .WIDTH        (AURORA_WIDTH),
      .DEPTH        (FIFO_DEPTH),
      .AFULL_MARGIN (AFULL_MARGIN)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_req      (we_in),
      .wr_data     (data_in),
      .rd_en       (fifo_pop),
      .rd_data     (fifo_rd_data),
      .count       (fifo_count),
      .empty       (fifo_empty),
      .full        (full),
      .almost_full (almost_full),
      .wr_drop     (fifo_drop)
   );

   // FETCH is only entered with a non-empty buffer, so the pop always succeeds.
   assign fifo_pop = (state == EG_FETCH);
   assign tx_tlast = tx_tvalid;
   assign tx_tkeep = '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EG_IDLE;
         tx_tdata   <= '0;
         tx_tvalid  <= 1'b0;
         tx_pkt_cnt <= '0;
      end else begin
         unique case (state)
            EG_IDLE: begin
               tx_tdata  <= '0;
               tx_tvalid <= 1'b0;
               if (channel_up && !fifo_empty) begin
                  state <= EG_FETCH;
               end
            end
            EG_FETCH: begin
               tx_tdata  <= fifo_rd_data;
               tx_tvalid <= 1'b1;
               state     <= EG_SEND;
            end
            EG_SEND: begin
               // Link loss only gates the next fetch; the offered beat stays up.
               if (tx_tready) begin
                  tx_tvalid  <= 1'b0;
                  tx_pkt_cnt <= wrap_inc16(tx_pkt_cnt);
                  if (channel_up && !fifo_empty) begin
                     state <= EG_FETCH;
                  end else begin
                     state    <= EG_IDLE;
                     tx_tdata <= '0;
                  end
               end
            end
            default: begin
               state     <= EG_IDLE;
               tx_tdata  <= '0;
               tx_tvalid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_cnt <= '0;
      end else if (fifo_drop) begin
         overflow_cnt <= sat_inc8(overflow_cnt);
      end
   end

endmodule

// File: tb/tb_egress_tx.sv
// Self-checking bench for egress_tx: scoreboard of accepted writes compared
// against TX handshakes, plus latency, overflow, backpressure, link and reset cases.
module tb_egress_tx;

   localparam int W = 256;

   logic           clk;
   logic           rst_n;
   logic           we_in;
   logic [W-1:0]   data_in;
   logic           full;
   logic           almost_full;
   logic           channel_up;
   logic [W-1:0]   tx_tdata;
   logic           tx_tvalid;
   logic           tx_tready;
   logic           tx_tlast;
   logic [W/8-1:0] tx_tkeep;
   logic [7:0]     overflow_cnt;
   logic [15:0]    tx_pkt_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] sb [$];

   egress_tx #(
      .AURORA_WIDTH (W),
      .FIFO_DEPTH   (8),
      .AFULL_MARGIN (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .we_in        (we_in),
      .data_in      (data_in),
      .full         (full),
      .almost_full  (almost_full),
      .channel_up   (channel_up),
      .tx_tdata     (tx_tdata),
      .tx_tvalid    (tx_tvalid),
      .tx_tready    (tx_tready),
      .tx_tlast     (tx_tlast),
      .tx_tkeep     (tx_tkeep),
      .overflow_cnt (overflow_cnt),
      .tx_pkt_cnt   (tx_pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_pkt(input logic [W-1:0] d, input bit accept);
      we_in   = 1'b1;
      data_in = d;
      if (accept) sb.push_back(d);
      tick();
      we_in   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      we_in      = 1'b0;
      channel_up = 1'b0;
      tx_tready  = 1'b0;
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_pkt(input int target, input string tag);
      int n = 0;
      while (tx_pkt_cnt != 16'(target) && n < 60) begin
         tick();
         n++;
      end
      check_val(tag, tx_pkt_cnt, target);
   endtask

   // Handshake monitor: sampled on the falling edge, accepted on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && tx_tvalid && tx_tready) begin
         if (sb.size() == 0) begin
            check_val("unexpected_beat", tx_tdata, '0);
            check_val("unexpected_beat_valid", 1'b1, 1'b0);
         end else begin
            check_val("sb_tdata", tx_tdata, sb.pop_front());
            check_val("sb_tlast", tx_tlast, 1'b1);
            check_val("sb_tkeep", tx_tkeep, {(W/8){1'b1}});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout got=1 exp=0");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int exp_c;
      rst_n      = 1'b0;
      we_in      = 1'b0;
      data_in    = '0;
      channel_up = 1'b0;
      tx_tready  = 1'b0;
      #2;
      check_val("rst_tvalid",   tx_tvalid, 0);
      check_val("rst_tlast",    tx_tlast, 0);
      check_val("rst_tdata",    tx_tdata, 0);
      check_val("rst_full",     full, 0);
      check_val("rst_afull",    almost_full, 0);
      check_val("rst_ovf",      overflow_cnt, 0);
      check_val("rst_pkt",      tx_pkt_cnt, 0);
      check_val("rst_tkeep",    tx_tkeep, {(W/8){1'b1}});

      // Latency: write at edge N, valid after N+2, counted after N+3.
      do_reset();
      channel_up = 1'b1;
      tx_tready  = 1'b1;
      write_pkt(256'hA5, 1'b1);
      check_val("lat_n0_tvalid", tx_tvalid, 0);
      tick();
      check_val("lat_n1_tvalid", tx_tvalid, 0);
      tick();
      check_val("lat_n2_tvalid", tx_tvalid, 1);
      check_val("lat_n2_tdata",  tx_tdata, 256'hA5);
      check_val("lat_n2_tlast",  tx_tlast, 1);
      tick();
      check_val("lat_n3_pkt",    tx_pkt_cnt, 1);
      check_val("lat_n3_tvalid", tx_tvalid, 0);
      check_val("lat_idle_tdata", tx_tdata, 0);

      // Overflow with the sink stalled; one entry sits in SEND, eight buffered.
      do_reset();
      channel_up = 1'b1;
      tx_tready  = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         write_pkt(256'h100 + W'(k - 1), k <= 9);
         exp_c = (k <= 2) ? k : ((k <= 9) ? k - 1 : 8);
         check_val($sformatf("ovf_full_w%0d", k),  full, exp_c == 8);
         check_val($sformatf("ovf_afull_w%0d", k), almost_full, exp_c >= 6);
         check_val($sformatf("ovf_cnt_w%0d", k),   overflow_cnt, (k > 9) ? k - 9 : 0);
      end
      check_val("ovf_tvalid", tx_tvalid, 1);
      check_val("ovf_head",   tx_tdata, 256'h100);

      for (int c = 0; c < 5; c++) begin
         tick();
         check_val($sformatf("bp_tdata_c%0d", c),  tx_tdata, 256'h100);
         check_val($sformatf("bp_tvalid_c%0d", c), tx_tvalid, 1);
      end

      for (int k = 0; k < 260; k++) begin
         write_pkt(256'hDEAD, 1'b0);
      end
      check_val("ovf_saturate", overflow_cnt, 255);
      check_val("ovf_pkt_none", tx_pkt_cnt, 0);

      // Release: nine packets at one per two cycles, in write order.
      tx_tready = 1'b1;
      for (int t = 1; t <= 17; t++) begin
         tick();
         if (t == 16) check_val("thru_pkt_t16", tx_pkt_cnt, 8);
      end
      check_val("thru_pkt_t17",  tx_pkt_cnt, 9);
      check_val("drain_tvalid",  tx_tvalid, 0);
      check_val("drain_tdata",   tx_tdata, 0);
      check_val("drain_full",    full, 0);
      check_val("drain_sb_left", sb.size(), 0);

      // Link down holds buffered entries until the link returns.
      do_reset();
      channel_up = 1'b0;
      tx_tready  = 1'b1;
      write_pkt(256'h11, 1'b1);
      write_pkt(256'h22, 1'b1);
      write_pkt(256'h33, 1'b1);
      for (int c = 0; c < 4; c++) begin
         tick();
         check_val($sformatf("link_dn_tvalid_c%0d", c), tx_tvalid, 0);
      end
      check_val("link_dn_count", dut.u_fifo.count, 3);
      channel_up = 1'b1;
      wait_pkt(3, "link_up_pkt");
      check_val("link_up_count", dut.u_fifo.count, 0);

      // Link drop during SEND keeps the beat offered, then blocks the next fetch.
      do_reset();
      channel_up = 1'b1;
      tx_tready  = 1'b0;
      write_pkt(256'h44, 1'b1);
      write_pkt(256'h55, 1'b1);
      tick();
      check_val("drop_send_tvalid", tx_tvalid, 1);
      check_val("drop_send_tdata",  tx_tdata, 256'h44);
      channel_up = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_val($sformatf("drop_hold_tvalid_c%0d", c), tx_tvalid, 1);
      end
      tx_tready = 1'b1;
      tick();
      check_val("drop_acc_pkt",   tx_pkt_cnt, 1);
      tick();
      tick();
      check_val("drop_idle_tvalid", tx_tvalid, 0);
      check_val("drop_kept_count",  dut.u_fifo.count, 1);
      channel_up = 1'b1;
      wait_pkt(2, "drop_resume_pkt");

      // Reset asserted mid-SEND discards everything.
      do_reset();
      channel_up = 1'b1;
      tx_tready  = 1'b0;
      for (int k = 0; k < 5; k++) write_pkt(256'h200 + W'(k), 1'b1);
      check_val("rs_pre_count",  dut.u_fifo.count, 4);
      check_val("rs_pre_tvalid", tx_tvalid, 1);
      #3;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_val("rs_tvalid", tx_tvalid, 0);
      check_val("rs_tlast",  tx_tlast, 0);
      check_val("rs_tdata",  tx_tdata, 0);
      check_val("rs_full",   full, 0);
      check_val("rs_afull",  almost_full, 0);
      check_val("rs_count",  dut.u_fifo.count, 0);
      check_val("rs_tkeep",  tx_tkeep, {(W/8){1'b1}});
      tick();
      rst_n     = 1'b1;
      tx_tready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_val($sformatf("rs_post_tvalid_c%0d", c), tx_tvalid, 0);
      end
      write_pkt(256'hBEEF, 1'b1);
      wait_pkt(1, "rs_new_pkt");
      tick();
      check_val("final_sb_left", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/egress_tx.md
EGRESS_TX -- requirements
Module: egress_tx

Interface
REQ-001 Parameter AURORA_WIDTH, default 256, data width of packets and Aurora TX user data.
REQ-002 Parameter FIFO_DEPTH, default 8, egress buffer entries; SHALL be a power of two, at least 4.
REQ-003 Parameter AFULL_MARGIN, default 2, free-entry threshold for almost_full.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 we_in  input  1  write strobe from the switch output port (we_output_port_N).
REQ-007 data_in  input  AURORA_WIDTH  packet from the switch (data_out_port_N).
REQ-008 full  output  1  buffer holds FIFO_DEPTH entries.
REQ-009 almost_full  output  1  free entries <= AFULL_MARGIN.
REQ-010 channel_up  input  1  Aurora link up.
REQ-011 tx_tdata  output  AURORA_WIDTH  Aurora AXI4-Stream TX data.
REQ-012 tx_tvalid  output  1  TX valid.
REQ-013 tx_tready  input  1  TX ready from the Aurora core.
REQ-014 tx_tlast  output  1  end of packet.
REQ-015 tx_tkeep  output  AURORA_WIDTH/8  byte enables.
REQ-016 overflow_cnt  output  8  dropped-write counter.
REQ-017 tx_pkt_cnt  output  16  sent-packet counter.

Function
REQ-018 Every packet SHALL be a single beat; tx_tlast SHALL equal tx_tvalid, and tx_tkeep SHALL be all ones.
REQ-019 A write SHALL occur on an edge where we_in=1 and full=0; count and the write pointer SHALL update on that edge.
REQ-020 A write with full=1 SHALL be dropped, and overflow_cnt SHALL increment, saturating at 255.
REQ-021 full and almost_full SHALL derive from the registered count only; a same-edge pop SHALL NOT admit a write while full=1.
REQ-022 The FSM SHALL have three states:
- IDLE: go to FETCH when channel_up=1 and count!=0.
- FETCH: pop one entry, register it into tx_tdata, go to SEND.
- SEND: tx_tvalid=1.
REQ-023 In SEND, on tx_tready=1 the FSM SHALL go to FETCH if channel_up=1 and count!=0 after the pop, otherwise to IDLE; tx_pkt_cnt SHALL increment, wrapping at 65535.
REQ-024 In SEND with tx_tready=0, tx_tdata and tx_tvalid SHALL be held stable; tx_tvalid SHALL never be retracted before acceptance.
REQ-025 A channel_up drop while in SEND SHALL NOT retract tx_tvalid; it SHALL only block further FETCH transitions. Buffered entries SHALL be retained.
REQ-026 Latency: with an empty buffer, IDLE state, and channel_up=1, a packet written at edge N SHALL have tx_tvalid=1 after edge N+2.
REQ-027 Throughput SHALL be one packet per two cycles with tx_tready held at 1.
REQ-028 A simultaneous write and pop SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 tx_tdata SHALL be 0 whenever the FSM is in IDLE.

Reset
REQ-030 On rst_n=0, the FSM SHALL go to IDLE; pointers, count, overflow_cnt, tx_pkt_cnt and tx_tdata SHALL be 0; tx_tvalid, tx_tlast, full and almost_full SHALL be 0.
REQ-031 tx_tkeep SHALL be all ones at all times, including reset.
REQ-032 Reset asserted mid-SEND SHALL drop the in-flight packet and discard all buffered entries.

Structure
REQ-033 Shared package router_pkg SHALL hold AURORA_WIDTH, ROUTER_WIDTH and the egress_tx state encoding (IDLE=2'b00, FETCH=2'b01, SEND=2'b10).
REQ-034 Buffer storage, pointers, count and flags SHALL be a sub-module egress_fifo; egress_tx SHALL hold the FSM, TX registers and counters.
REQ-035 One egress_tx SHALL be instantiated per switch output port (0, 1, 2).

Verification
REQ-036 Latency check: channel_up=1, tx_tready=1, write 0xA5 at edge 10 -> tx_tvalid=1, tx_tdata=0xA5, tx_tlast=1 after edge 12; tx_pkt_cnt=1 after edge 13.
REQ-037 Overflow: tx_tready=0, 12 back-to-back writes with FIFO_DEPTH=8 -> one entry popped into SEND; full=1 once 8 are buffered; overflow_cnt=3; almost_full=1 from the 6th buffered entry.
REQ-038 Backpressure: tx_tready=0 for 5 cycles in SEND -> tx_tdata stable; on release, packets drain in write order, with no loss or duplication.
REQ-039 Link down: channel_up=0 with 3 buffered entries -> FSM stays in IDLE, count=3; channel_up=1 -> all 3 sent, tx_pkt_cnt=3.
REQ-040 Reset mid-SEND with 4 buffered entries -> all outputs return to reset values and count=0; after release, tx_tvalid stays 0 until a new write.
